// File: rtl/pwm_deadtime.sv
// Complementary gate pair with programmable dead band from a single-ended PWM command.
// Optional fault latch and shutdown enabled by defining PWM_DT_FAULT_EN.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
`ifdef PWM_DT_FAULT_EN
    input  logic                fault,
    input  logic                fault_clr,
    output logic                fault_latched,
`endif
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                dead_active
);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_LO_ON      = 3'd1,
        ST_DEAD_TO_HI = 3'd2,
        ST_HI_ON      = 3'd3,
        ST_DEAD_TO_LO = 3'd4
`ifdef PWM_DT_FAULT_EN
        ,
        ST_FAULT      = 3'd5
`endif
    } state_t;

    state_t              r_state;
    logic [DT_WIDTH-1:0] r_cnt;
    state_t              w_nextState;
    logic [DT_WIDTH-1:0] w_nextCnt;

`ifdef PWM_DT_FAULT_EN
    logic r_faultSync1;
    logic r_faultSync2;
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        if (!enable) begin
            w_nextState = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_nextState = pwm_in ? ST_DEAD_TO_HI : ST_DEAD_TO_LO;
                    w_nextCnt   = dead_time;
                end
                ST_LO_ON: begin
                    if (pwm_in) begin
                        w_nextState = (dead_time == '0) ? ST_HI_ON : ST_DEAD_TO_HI;
                        w_nextCnt   = dead_time;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_in) begin
                        w_nextState = (dead_time == '0) ? ST_LO_ON : ST_DEAD_TO_LO;
                        w_nextCnt   = dead_time;
                    end
                end
                // A command reversal mid-band restarts the full band toward the other side.
                ST_DEAD_TO_HI: begin
                    if (pwm_in) begin
                        if (r_cnt <= DT_WIDTH'(1)) begin
                            w_nextState = ST_HI_ON;
                        end else begin
                            w_nextCnt = r_cnt - DT_WIDTH'(1);
                        end
                    end else begin
                        w_nextState = ST_DEAD_TO_LO;
                        w_nextCnt   = dead_time;
                    end
                end
                ST_DEAD_TO_LO: begin
                    if (!pwm_in) begin
                        if (r_cnt <= DT_WIDTH'(1)) begin
                            w_nextState = ST_LO_ON;
                        end else begin
                            w_nextCnt = r_cnt - DT_WIDTH'(1);
                        end
                    end else begin
                        w_nextState = ST_DEAD_TO_HI;
                        w_nextCnt   = dead_time;
                    end
                end
                default: begin
                    w_nextState = ST_OFF;
                end
            endcase
        end
`ifdef PWM_DT_FAULT_EN
        if (r_faultSync2) begin
            w_nextState = ST_FAULT;
        end else if (r_state == ST_FAULT) begin
            w_nextState = fault_clr ? ST_OFF : ST_FAULT;
        end
`endif
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            pwm_hi      <= 1'b0;
            pwm_lo      <= 1'b0;
            dead_active <= 1'b0;
`ifdef PWM_DT_FAULT_EN
            r_faultSync1  <= 1'b0;
            r_faultSync2  <= 1'b0;
            fault_latched <= 1'b0;
`endif
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            pwm_hi      <= (w_nextState == ST_HI_ON);
            pwm_lo      <= (w_nextState == ST_LO_ON);
            dead_active <= (w_nextState == ST_DEAD_TO_HI) || (w_nextState == ST_DEAD_TO_LO);
`ifdef PWM_DT_FAULT_EN
            r_faultSync1  <= fault;
            r_faultSync2  <= r_faultSync1;
            fault_latched <= (w_nextState == ST_FAULT);
`endif
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: stimulus pushes expected gate states, a negedge monitor pops and compares.
// Fault scenarios run only when PWM_DT_FAULT_EN is defined.
module tb_pwm_deadtime;

    typedef struct {
        logic  hi;
        logic  lo;
        logic  dead;
        logic  latched;
        string name;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pwmIn = 1'b0;
    logic [7:0] deadTime = 8'd0;
    logic       pwmHi;
    logic       pwmLo;
    logic       deadActive;
    logic       expLatched = 1'b0;
`ifdef PWM_DT_FAULT_EN
    logic       fault = 1'b0;
    logic       faultClr = 1'b0;
    logic       faultLatched;
`endif

    expect_t scoreboard[$];
    int      checkCount = 0;
    int      passCount = 0;

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
`ifdef PWM_DT_FAULT_EN
        .fault(fault),
        .fault_clr(faultClr),
        .fault_latched(faultLatched),
`endif
        .enable(enable),
        .pwm_in(pwmIn),
        .dead_time(deadTime),
        .pwm_hi(pwmHi),
        .pwm_lo(pwmLo),
        .dead_active(deadActive)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one input vector per cycle for n cycles and queues the gate state expected after each edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic pwm, input logic [7:0] dt,
                                 input logic eHi, input logic eLo, input logic eDead,
                                 input int n, input string name);
        expect_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = rst;
            enable   = en;
            pwmIn    = pwm;
            deadTime = dt;
            @(posedge clk);
            e.hi      = eHi;
            e.lo      = eLo;
            e.dead    = eDead;
            e.latched = expLatched;
            e.name    = $sformatf("%s[%0d]", name, i);
            scoreboard.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        expect_t e;
        checkOutput("overlap", int'(pwmHi & pwmLo), 0);
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput({e.name, ".hi"}, int'(pwmHi), int'(e.hi));
            checkOutput({e.name, ".lo"}, int'(pwmLo), int'(e.lo));
            checkOutput({e.name, ".dead"}, int'(deadActive), int'(e.dead));
`ifdef PWM_DT_FAULT_EN
            checkOutput({e.name, ".latched"}, int'(faultLatched), int'(e.latched));
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1, 0, 0, 8'd0, 0, 0, 0, 2, "reset");
        applyStimulus(0, 1, 0, 8'd3, 0, 0, 1, 3, "startDead");
        applyStimulus(0, 1, 0, 8'd3, 0, 1, 0, 3, "loOn");
        applyStimulus(0, 1, 1, 8'd4, 0, 0, 1, 4, "deadToHi");
        applyStimulus(0, 1, 1, 8'd4, 1, 0, 0, 2, "hiOn");
        applyStimulus(0, 1, 0, 8'd4, 0, 0, 1, 4, "deadToLo");
        applyStimulus(0, 1, 0, 8'd4, 0, 1, 0, 1, "loOn2");
        applyStimulus(0, 1, 1, 8'd6, 0, 0, 1, 1, "glitchHi");
        applyStimulus(0, 1, 0, 8'd6, 0, 0, 1, 6, "glitchReload");
        applyStimulus(0, 1, 0, 8'd6, 0, 1, 0, 2, "glitchLo");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 1, 8'd0, 1, 0, 0, 5, "dt0Hi");
            applyStimulus(0, 1, 0, 8'd0, 0, 1, 0, 5, "dt0Lo");
        end
        applyStimulus(0, 1, 1, 8'd3, 0, 0, 1, 2, "midBand");
        applyStimulus(0, 0, 1, 8'd3, 0, 0, 0, 2, "disable");
        applyStimulus(0, 1, 1, 8'd2, 0, 0, 1, 2, "reDead");
        applyStimulus(0, 1, 1, 8'd2, 1, 0, 0, 2, "reHi");

        // Async reset lands between edges; gates must drop without waiting for a clock.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncReset.hi", int'(pwmHi), 0);
        checkOutput("asyncReset.lo", int'(pwmLo), 0);
        checkOutput("asyncReset.dead", int'(deadActive), 0);
        applyStimulus(1, 1, 1, 8'd0, 0, 0, 0, 1, "inReset");
        applyStimulus(0, 1, 1, 8'd0, 0, 0, 1, 1, "offDt0");
        applyStimulus(0, 1, 1, 8'd0, 1, 0, 0, 2, "hiDt0");
        applyStimulus(0, 1, 0, 8'd0, 0, 1, 0, 2, "swapDt0");

`ifdef PWM_DT_FAULT_EN
        applyStimulus(0, 1, 1, 8'd0, 1, 0, 0, 2, "hiPreFault");
        fault = 1'b1;
        applyStimulus(0, 1, 1, 8'd0, 1, 0, 0, 2, "faultSync");
        expLatched = 1'b1;
        applyStimulus(0, 1, 1, 8'd0, 0, 0, 0, 1, "faultEntry");
        faultClr = 1'b1;
        applyStimulus(0, 1, 1, 8'd0, 0, 0, 0, 1, "clrIgnored");
        fault = 1'b0;
        faultClr = 1'b0;
        applyStimulus(0, 1, 1, 8'd2, 0, 0, 0, 2, "faultHold");
        faultClr = 1'b1;
        expLatched = 1'b0;
        applyStimulus(0, 1, 1, 8'd2, 0, 0, 0, 1, "faultExit");
        faultClr = 1'b0;
        applyStimulus(0, 1, 1, 8'd2, 0, 0, 1, 2, "postFaultDead");
        applyStimulus(0, 1, 1, 8'd2, 1, 0, 0, 1, "postFaultHi");
`endif

        @(negedge clk);
        #1;
        checkOutput("drain", scoreboard.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the PWM generator: consumes its single-ended pwm_out and produces a complementary high-side/low-side gate pair.
- Inserts a programmable dead band so that neither gate is ever high with the other, and both are low for exactly dead_time cycles at every switch-over.
- Sits between the PWM generator and the half-bridge gate-driver pins, in the same clock domain as the generator.

Parameters:
- DT_WIDTH, 8, width of the dead_time input and the internal dead-band counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = drive the gates; 0 = force both gates low (OFF state).
- pwm_in  input  1  PWM command from the PWM generator, synchronous to clk.
- dead_time  input  DT_WIDTH  dead band length in clk cycles; 0 = no dead band.
- pwm_hi  output  1  high-side gate, registered.
- pwm_lo  output  1  low-side gate, registered.
- dead_active  output  1  registered; 1 while in either DEAD state.

Behaviour:
- Reset (async, active-high): state=OFF, cnt=0, pwm_hi=0, pwm_lo=0, dead_active=0. Reset mid-dead-band aborts immediately, with no glitch on the outputs.
- Outputs are a registered decode of the state:
  - HI_ON: hi=1, lo=0.
  - LO_ON: hi=0, lo=1.
  - DEAD_TO_HI, DEAD_TO_LO: hi=0, lo=0, dead_active=1.
  - OFF: all outputs 0.
- Invariant: pwm_hi & pwm_lo is 0 in every cycle, including dead_time=0 and all abort paths.
- States: OFF, LO_ON, DEAD_TO_HI, HI_ON, DEAD_TO_LO.
- enable=0: next edge goes to OFF from any state; takes priority over all other transitions.
- OFF with enable=1: enter DEAD_TO_HI if pwm_in=1, else DEAD_TO_LO, loading cnt<=dead_time.
- LO_ON with pwm_in=1: next edge to DEAD_TO_HI, cnt<=dead_time.
- HI_ON with pwm_in=0: next edge to DEAD_TO_LO, cnt<=dead_time.
- DEAD_TO_x, pwm_in still at the target level:
  - cnt<=1: go to x_ON.
  - otherwise: cnt<=cnt-1.
  - Result: both gates low for exactly max(dead_time,1) cycles when entered from an ON or OFF state.
- dead_time=0: no dead band. The ON state switches directly to the opposite ON state on the edge that samples the new pwm_in level (hi and lo swap on the same edge). DEAD states are only reached from OFF and exit after 1 cycle.
- Latency: pwm_in change sampled at edge E. The active gate drops at E; the opposite gate rises at E+dead_time (E+1 when leaving OFF with dead_time=0).
- Abort during a dead band: if pwm_in returns to the level opposite the target, next edge switches to the other DEAD state and reloads cnt<=dead_time (full band restarted). Pulses shorter than the dead band therefore never reach a gate.
- dead_time is sampled only on a dead-band load; changes mid-band are ignored.
- cnt is DT_WIDTH bits and never wraps: it is only decremented while >1.

Optional Feature:
- Macro PWM_DT_FAULT_EN.
- When defined, adds:
  - input fault (1b): async-sampled by a 2-flop synchroniser.
  - input fault_clr (1b).
  - output fault_latched (1b, reset 0).
  - state FAULT.
- Fault entry: synchronised fault=1 moves any state to FAULT on the next edge.
- In FAULT: pwm_hi=pwm_lo=0, dead_active=0, fault_latched=1.
- FAULT exit: only on an edge with fault_clr=1 and synchronised fault=0, going to OFF with fault_latched<=0.
- Priority: reset > fault > enable.
- When undefined: the ports and the FAULT state do not exist, and behaviour is exactly as above.

Test Plan:
- Reset held, then released with enable=1, pwm_in=0, dead_time=3 -> hi=lo=0 and dead_active=1 for 3 cycles, then lo=1.
- In LO_ON with dead_time=4, pwm_in rises at edge E -> lo=0 at E, hi=1 at E+4; hi&lo never both 1.
- dead_time=0, pwm_in toggles every 5 cycles -> hi and lo swap on the sampling edge, dead_active stays 0, no overlap.
- dead_time=6, pwm_in 1-cycle high glitch while in LO_ON -> DEAD_TO_HI then DEAD_TO_LO with reload; hi stays 0 and lo returns after 6 more cycles.
- Assert enable=0 mid-band with cnt=2, and separately assert async reset mid HI_ON -> both gates low (next edge / immediately), state OFF.
- With PWM_DT_FAULT_EN: fault pulse during HI_ON -> hi=0 within 3 edges and fault_latched=1; fault_clr while fault=1 is ignored; fault_clr after fault=0 -> OFF, then normal dead-band restart.
